// File: rtl/seq_div16_8_pkg.sv
// seq_div16_8_pkg: widths and FSM state encoding shared by the divider files
package seq_div16_8_pkg;
    localparam int DW = 16;
    localparam int VW = 8;
    localparam int CW = $clog2(DW);
    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;
endpackage

// File: rtl/seq_div16_8_if.sv
// seq_div16_8_if: operand and result valid/ready handshakes of the divider
interface seq_div16_8_if;
    import seq_div16_8_pkg::*;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div16_8_step.sv
// seq_div16_8_step: one restoring step, shift in a dividend bit then compare/subtract
module seq_div16_8_step
    import seq_div16_8_pkg::*;
(
    input  logic [VW-1:0] rem_in,
    input  logic          msb_in,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] rem_out,
    output logic          qbit
);
    logic [VW:0]   r9;
    logic [VW+1:0] diff;
    always_comb begin
        r9      = {rem_in, msb_in};
        diff    = {1'b0, r9} - {2'b00, divisor};
        qbit    = ~diff[VW+1];
        rem_out = qbit ? diff[VW-1:0] : r9[VW-1:0];
    end
endmodule

// File: rtl/seq_div16_8.sv
// seq_div16_8: sequential restoring 16/8 divider, one quotient bit per clock
module seq_div16_8
    import seq_div16_8_pkg::*;
(
    input logic         clk,
    input logic         rst,
    seq_div16_8_if.slave bus
);
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] wk_q, wk_d;
    logic [VW-1:0] rem_q, rem_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [VW-1:0] rmo_q, rmo_d;
    logic          dbz_q, dbz_d;
    logic          ov_q, ov_d;
    logic [VW-1:0] rem_nx;
    logic          qbit;

    // wk_q shifts the dividend out of its MSB while quotient bits fill the LSB
    seq_div16_8_step u_step (
        .rem_in  (rem_q),
        .msb_in  (wk_q[DW-1]),
        .divisor (dvs_q),
        .rem_out (rem_nx),
        .qbit    (qbit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wk_d    = wk_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmo_d   = rmo_q;
        dbz_d   = dbz_q;
        ov_d    = ov_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid) begin
                wk_d    = bus.dividend;
                dvs_d   = bus.divisor;
                rem_d   = '0;
                cnt_d   = '0;
                state_d = (bus.divisor == '0) ? ST_DONE : ST_CALC;
            end
            ST_CALC: begin
                wk_d  = {wk_q[DW-2:0], qbit};
                rem_d = rem_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = ST_DONE;
                    ov_d    = 1'b1;
                    quo_d   = {wk_q[DW-2:0], qbit};
                    rmo_d   = rem_nx;
                    dbz_d   = 1'b0;
                end
            end
            ST_DONE: if (!ov_q) begin
                // only a zero divisor reaches DONE without a published result
                ov_d  = 1'b1;
                quo_d = '1;
                rmo_d = wk_q[VW-1:0];
                dbz_d = 1'b1;
            end else if (bus.out_ready) begin
                ov_d    = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wk_q    <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rmo_q   <= '0;
            dbz_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wk_q    <= wk_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmo_q   <= rmo_d;
            dbz_q   <= dbz_d;
            ov_q    <= ov_d;
        end
    end

    assign bus.in_ready    = state_q == ST_IDLE;
    assign bus.out_valid   = ov_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmo_q;
    assign bus.div_by_zero = dbz_q;
endmodule
